// File: rtl/new_usb_dmawritebacked_pkg.sv
// ED writeback types: endpoint descriptor layout, queued writeback request,
// FSM encoding and the dword packing helper shared by the writeback datapath.
`default_nettype none

package new_usb_dmawritebacked_pkg;

  typedef struct packed {
    logic [10:0] mps;
    logic        f;
    logic        k;
    logic        s;
    logic [1:0]  d;
    logic [3:0]  en;
    logic [6:0]  fa;
    logic [27:0] headp;
    logic        c;
    logic        h;
    logic [27:0] nextp;
  } endpoint_descriptor;

  typedef struct packed {
    endpoint_descriptor ed;
    logic [27:0]        tailp;
    logic [27:0]        addr;
    logic               full;
  } ed_writeback_req;

  localparam int ED_DWORDS      = 4;
  localparam int ED_HEADP_DWORD = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } wb_state_e;

  // OHCI in-memory ED layout, one dword per index.
  function automatic logic [31:0] ed_dword(input endpoint_descriptor ed,
                                           input logic [27:0] tailp,
                                           input logic [1:0] idx);
    logic [31:0] d;
    case (idx)
      2'd0:    d = {5'b0, ed.mps, ed.f, ed.k, ed.s, ed.d, ed.en, ed.fa};
      2'd1:    d = {tailp, 4'b0};
      2'd2:    d = {ed.headp, 2'b0, ed.c, ed.h};
      default: d = {ed.nextp, 4'b0};
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/new_usb_dmawritebacked_fifo.sv
// Small synchronous FIFO of ED writeback requests with a same-cycle flush.
`default_nettype none

module new_usb_dmawritebacked_fifo
  import new_usb_dmawritebacked_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            i_flush,
  input  logic            i_push,
  input  ed_writeback_req i_data,
  input  logic            i_pop,
  output ed_writeback_req o_data,
  output logic            o_full,
  output logic            o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  ed_writeback_req  r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_cnt;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_full    = (r_cnt == CNT_W'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign o_data    = r_mem[r_rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= f_inc(r_wptr);
      if (w_do_pop)  r_rptr <= f_inc(r_rptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

endmodule

`default_nettype wire

// File: rtl/new_usb_dmawritebacked.sv
// Endpoint-descriptor writeback engine: queues requests and serialises each
// into OHCI ED dwords on a valid/ready DMA write channel (full or head-only).
`default_nettype none

module new_usb_dmawritebacked
  import new_usb_dmawritebacked_pkg::*;
#(
  parameter int QueueDepth = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  endpoint_descriptor req_ed_i,
  input  logic [27:0]        req_tailp_i,
  input  logic [27:0]        req_addr_i,
  input  logic               req_full_i,
  input  logic               flush_i,
  output logic [31:0]        dma_addr_o,
  output logic [31:0]        dma_data_o,
  output logic               dma_valid_o,
  input  logic               dma_ready_i,
  output logic               dma_last_o,
  output logic               busy_o,
  output logic               done_o
);

  wb_state_e       r_state;
  wb_state_e       w_state_nxt;
  ed_writeback_req r_req;
  logic [1:0]      r_idx;
  logic [1:0]      w_idx_nxt;
  ed_writeback_req w_in;
  ed_writeback_req w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic            w_last;
  logic            w_send;

  assign w_in = '{ed: req_ed_i, tailp: req_tailp_i, addr: req_addr_i, full: req_full_i};

  // A flush in the same cycle as a request drops the request.
  assign w_push      = req_valid_i && !w_full && !flush_i;
  assign req_ready_o = !w_full;

  new_usb_dmawritebacked_fifo #(
    .DEPTH (QueueDepth)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_flush (flush_i),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_send = (r_state == ST_SEND);
  assign w_last = r_req.full ? (r_idx == 2'(ED_DWORDS - 1)) : 1'b1;

  // Dword n lives at base + 4n; base is 16-byte aligned so no carry.
  assign dma_addr_o = w_send ? {r_req.addr, r_idx, 2'b00} : 32'h0;
  assign dma_data_o = w_send ? ed_dword(r_req.ed, r_req.tailp, r_idx) : 32'h0;
  assign dma_last_o = w_send && w_last;
  assign busy_o     = !w_empty || (r_state != ST_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_pop       = 1'b0;
    dma_valid_o = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !flush_i) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_SEND;
          w_idx_nxt   = w_head.full ? 2'd0 : 2'(ED_HEADP_DWORD);
        end
      end
      ST_SEND: begin
        dma_valid_o = 1'b1;
        if (dma_ready_i) begin
          if (w_last) w_state_nxt = ST_DONE;
          else        w_idx_nxt   = r_idx + 2'd1;
        end
      end
      ST_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_idx   <= 2'd0;
      r_req   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_pop) r_req <= w_head;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_new_usb_dmawritebacked.sv
// Self-checking bench for the ED writeback engine: directed scenarios plus
// randomized traffic against a queue-based model of the expected DMA writes.
`timescale 1ns/1ps
`default_nettype none

module tb_new_usb_dmawritebacked;
  import new_usb_dmawritebacked_pkg::*;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               req_valid_i;
  logic               req_ready_o;
  endpoint_descriptor req_ed_i;
  logic [27:0]        req_tailp_i;
  logic [27:0]        req_addr_i;
  logic               req_full_i;
  logic               flush_i;
  logic [31:0]        dma_addr_o;
  logic [31:0]        dma_data_o;
  logic               dma_valid_o;
  logic               dma_ready_i;
  logic               dma_last_o;
  logic               busy_o;
  logic               done_o;

  always #5 clk_i = ~clk_i;

  new_usb_dmawritebacked #(.QueueDepth(2)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_ed_i    (req_ed_i),
    .req_tailp_i (req_tailp_i),
    .req_addr_i  (req_addr_i),
    .req_full_i  (req_full_i),
    .flush_i     (flush_i),
    .dma_addr_o  (dma_addr_o),
    .dma_data_o  (dma_data_o),
    .dma_valid_o (dma_valid_o),
    .dma_ready_i (dma_ready_i),
    .dma_last_o  (dma_last_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int s_cyc        = 0;
  int last_hs_cyc  = -10;
  int done_cyc     = -20;
  logic rand_ready = 1'b0;

  logic [64:0] obs_q[$];
  logic [64:0] exp_q[$];

  logic        s_valid, s_req_ready, s_busy, s_done, s_last;
  logic [31:0] s_addr, s_data;

  // One clock: sample at negedge, then advance to just after the posedge.
  task automatic step();
    @(negedge clk_i);
    s_cyc       = cyc;
    s_valid     = dma_valid_o;
    s_req_ready = req_ready_o;
    s_busy      = busy_o;
    s_done      = done_o;
    s_last      = dma_last_o;
    s_addr      = dma_addr_o;
    s_data      = dma_data_o;
    if (dma_valid_o && dma_ready_i) begin
      obs_q.push_back({dma_addr_o, dma_data_o, dma_last_o});
      if (dma_last_o) last_hs_cyc = cyc;
    end
    if (done_o) done_cyc = cyc;
    @(posedge clk_i);
    #1;
    cyc++;
    if (rand_ready) dma_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  function automatic void model_req(input ed_writeback_req r);
    logic [31:0] base;
    logic [31:0] dw [4];
    base  = 32'(r.addr) * 16;
    dw[0] = 32'(r.ed.mps) * 65536 + 32'(r.ed.f) * 32768 + 32'(r.ed.k) * 16384
          + 32'(r.ed.s) * 8192 + 32'(r.ed.d) * 2048 + 32'(r.ed.en) * 128 + 32'(r.ed.fa);
    dw[1] = 32'(r.tailp) * 16;
    dw[2] = 32'(r.ed.headp) * 16 + 32'(r.ed.c) * 2 + 32'(r.ed.h);
    dw[3] = 32'(r.ed.nextp) * 16;
    if (r.full) begin
      for (int n = 0; n < 4; n++) exp_q.push_back({base + 32'(4 * n), dw[n], (n == 3)});
    end else begin
      exp_q.push_back({base + 32'd8, dw[2], 1'b1});
    end
  endfunction

  function automatic ed_writeback_req rand_req();
    logic [159:0] bits;
    bits = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return bits[141:0];
  endfunction

  task automatic send_req(input ed_writeback_req r, input bit use_model, output bit ok);
    req_ed_i    = r.ed;
    req_tailp_i = r.tailp;
    req_addr_i  = r.addr;
    req_full_i  = r.full;
    req_valid_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      if (s_req_ready) ok = 1'b1;
    end
    req_valid_i = 1'b0;
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL req_accept: request not accepted within 200 cycles (got ready=0, expected 1)");
    end else if (use_model) begin
      model_req(r);
    end
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    do begin
      step();
      n++;
    end while (s_busy && n < max_cycles);
    tests_run++;
    if (s_busy) begin
      tests_failed++;
      $display("FAIL drain_timeout: busy_o still 1 after %0d cycles, expected 0", max_cycles);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; req_valid_i = 1'b0; flush_i = 1'b0; dma_ready_i = 1'b0;
    req_ed_i = '0; req_tailp_i = '0; req_addr_i = '0; req_full_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    tests_run++;
    if ({req_ready_o, dma_valid_o, dma_last_o, busy_o, done_o} !== 5'b10000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: {ready,valid,last,busy,done}=%b, expected 10000",
               {req_ready_o, dma_valid_o, dma_last_o, busy_o, done_o});
    end
    tests_run++;
    if ({dma_addr_o, dma_data_o} !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_bus: addr=%h data=%h, expected 0/0", dma_addr_o, dma_data_o);
    end
    rst_ni = 1'b1;
    step();
    step();
  endtask

  task automatic test_full_writeback();
    ed_writeback_req r;
    bit ok;
    int lat;
    obs_q.delete(); exp_q.delete();
    r = '0;
    r.addr = 28'h100; r.ed.mps = 11'd64; r.ed.fa = 7'd5; r.ed.en = 4'd1;
    r.tailp = 28'h200; r.ed.headp = 28'h100; r.ed.c = 1'b1; r.ed.h = 1'b0;
    r.ed.nextp = 28'h300; r.full = 1'b1;
    exp_q.push_back({32'h0000_1000, 32'h0040_0085, 1'b0});
    exp_q.push_back({32'h0000_1004, 32'h0000_2000, 1'b0});
    exp_q.push_back({32'h0000_1008, 32'h0000_1002, 1'b0});
    exp_q.push_back({32'h0000_100C, 32'h0000_3000, 1'b1});
    rand_ready = 1'b0; dma_ready_i = 1'b1;
    last_hs_cyc = -10; done_cyc = -20;
    send_req(r, 1'b0, ok);
    lat = 0;
    for (int i = 1; i <= 6 && lat == 0; i++) begin
      step();
      if (s_valid) lat = i;
    end
    tests_run++;
    if (lat != 2) begin
      tests_failed++;
      $display("FAIL full_latency: first valid %0d cycles after accept, expected 2", lat);
    end
    drain(50);
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL full_count: got %0d dwords, expected %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (obs_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL full_dword%0d: got addr=%h data=%h last=%b, expected addr=%h data=%h last=%b",
                   i, obs_q[i][64:33], obs_q[i][32:1], obs_q[i][0],
                   exp_q[i][64:33], exp_q[i][32:1], exp_q[i][0]);
        end
      end
    end
    tests_run++;
    if (done_cyc != last_hs_cyc + 1) begin
      tests_failed++;
      $display("FAIL full_done: done at cycle %0d, expected %0d", done_cyc, last_hs_cyc + 1);
    end
  endtask

  task automatic test_head_only();
    ed_writeback_req r;
    bit ok;
    obs_q.delete(); exp_q.delete();
    r = rand_req();
    r.addr = 28'h200; r.ed.headp = 28'hABC; r.ed.c = 1'b0; r.ed.h = 1'b1; r.full = 1'b0;
    exp_q.push_back({32'h0000_2008, 32'h0000_ABC1, 1'b1});
    rand_ready = 1'b0; dma_ready_i = 1'b1;
    send_req(r, 1'b0, ok);
    drain(50);
    tests_run++;
    if (obs_q.size() != 1) begin
      tests_failed++;
      $display("FAIL head_count: got %0d dwords, expected 1", obs_q.size());
    end else begin
      tests_run++;
      if (obs_q[0] !== exp_q[0]) begin
        tests_failed++;
        $display("FAIL head_dword: got addr=%h data=%h last=%b, expected addr=%h data=%h last=%b",
                 obs_q[0][64:33], obs_q[0][32:1], obs_q[0][0],
                 exp_q[0][64:33], exp_q[0][32:1], exp_q[0][0]);
      end
    end
  endtask

  task automatic test_backpressure();
    ed_writeback_req r;
    bit ok;
    logic [64:0] hold_v;
    obs_q.delete(); exp_q.delete();
    r = rand_req();
    r.full = 1'b1;
    rand_ready = 1'b0; dma_ready_i = 1'b1;
    send_req(r, 1'b1, ok);
    for (int i = 0; i < 20 && obs_q.size() < 2; i++) step();
    dma_ready_i = 1'b0;
    step();
    hold_v = {s_addr, s_data, s_last};
    tests_run++;
    if (s_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_valid: valid=%b at stall start, expected 1", s_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      tests_run++;
      if ({s_valid, s_addr, s_data, s_last} !== {1'b1, hold_v}) begin
        tests_failed++;
        $display("FAIL bp_stable: valid=%b addr=%h data=%h last=%b, expected 1 %h %h %b",
                 s_valid, s_addr, s_data, s_last, hold_v[64:33], hold_v[32:1], hold_v[0]);
      end
    end
    dma_ready_i = 1'b1;
    drain(50);
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL bp_count: got %0d dwords, expected %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (obs_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL bp_dword%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_queue_full();
    ed_writeback_req r;
    bit ok;
    bit rose;
    obs_q.delete(); exp_q.delete();
    rand_ready = 1'b0; dma_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r = rand_req();
      r.full = (i != 2);
      send_req(r, 1'b1, ok);
    end
    step();
    tests_run++;
    if (s_req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL qfull_ready: req_ready=%b with queue full, expected 0", s_req_ready);
    end
    dma_ready_i = 1'b1;
    rose = 1'b0;
    for (int i = 0; i < 30 && !rose; i++) begin
      step();
      if (s_req_ready) rose = 1'b1;
    end
    tests_run++;
    if (!rose || obs_q.size() < 4) begin
      tests_failed++;
      $display("FAIL qfull_reassert: rose=%b after %0d dwords, expected 1 after >=4", rose, obs_q.size());
    end
    drain(100);
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL qfull_count: got %0d dwords, expected %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (obs_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL qfull_dword%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_flush();
    ed_writeback_req r;
    bit ok;
    obs_q.delete(); exp_q.delete();
    rand_ready = 1'b0; dma_ready_i = 1'b0;
    last_hs_cyc = -10; done_cyc = -20;
    r = rand_req(); r.full = 1'b1;
    send_req(r, 1'b1, ok);
    r = rand_req();
    send_req(r, 1'b0, ok);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    dma_ready_i = 1'b1;
    drain(50);
    tests_run++;
    if (s_cyc != done_cyc + 1) begin
      tests_failed++;
      $display("FAIL flush_busy: busy fell at cycle %0d, expected %0d", s_cyc, done_cyc + 1);
    end
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL flush_count: got %0d dwords, expected %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (obs_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL flush_dword%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
    obs_q.delete();
    r = rand_req();
    req_ed_i = r.ed; req_tailp_i = r.tailp; req_addr_i = r.addr; req_full_i = r.full;
    req_valid_i = 1'b1; flush_i = 1'b1;
    step();
    req_valid_i = 1'b0; flush_i = 1'b0;
    tests_run++;
    if (s_req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL flush_req_ready: req_ready=%b during flush, expected 1", s_req_ready);
    end
    repeat (4) step();
    tests_run++;
    if (obs_q.size() != 0 || s_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_drop: got %0d dwords busy=%b, expected 0 dwords busy=0", obs_q.size(), s_busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    ed_writeback_req r;
    bit ok;
    obs_q.delete(); exp_q.delete();
    rand_ready = 1'b0; dma_ready_i = 1'b1;
    r = rand_req(); r.full = 1'b1;
    send_req(r, 1'b0, ok);
    for (int i = 0; i < 20 && obs_q.size() < 1; i++) step();
    rst_ni = 1'b0;
    #1;
    tests_run++;
    if ({req_ready_o, dma_valid_o, dma_last_o, busy_o, done_o, dma_addr_o, dma_data_o}
        !== {5'b10000, 64'h0}) begin
      tests_failed++;
      $display("FAIL rst_mid: ready=%b valid=%b last=%b busy=%b done=%b addr=%h data=%h, expected 1 0 0 0 0 0 0",
               req_ready_o, dma_valid_o, dma_last_o, busy_o, done_o, dma_addr_o, dma_data_o);
    end
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    step();
    obs_q.delete();
    r = rand_req();
    send_req(r, 1'b1, ok);
    drain(50);
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL rst_after_count: got %0d dwords, expected %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (obs_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL rst_after_dword%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    ed_writeback_req r;
    bit ok;
    obs_q.delete(); exp_q.delete();
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      r = rand_req();
      send_req(r, 1'b1, ok);
      repeat ($urandom_range(0, 3)) step();
    end
    drain(2000);
    rand_ready = 1'b0; dma_ready_i = 1'b1;
    tests_run++;
    if (obs_q.size() != exp_q.size()) begin
      tests_failed++;
      $display("FAIL rand_count: got %0d dwords, expected %0d", obs_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests_run++;
        if (obs_q[i] !== exp_q[i]) begin
          tests_failed++;
          $display("FAIL rand_dword%0d: got %h, expected %h", i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_writeback();
    test_head_only();
    test_backpressure();
    test_queue_full();
    test_flush();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
